xbar_req_router: RTL and testbench

- Request crossbar directly upstream of the four bank_top instances.
- Accepts up to four channel requests per cycle, steers each to a bank using address bits, and arbitrates round-robin per bank when channels collide.
- Registers each bank-bound request in a one-entry output stage that drives the bank's xbar_bankN_htu_* valid/allowIn interface.

---
 rtl/xbar_req_router.sv | 130 +++++++++++++
 tb/tb_xbar_req_router.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_req_router.sv
// Request crossbar ahead of the four banks: steers channel requests by address,
// arbitrates round-robin per bank and holds each winner in a one-entry output stage.
module xbar_req_router #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned BANK_SEL_LSB = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_CH-1:0]    ch_valid_i,
    output logic [NUM_CH-1:0]    ch_allowIn_o,
    input  logic [NUM_CH*2-1:0]  ch_opcode_i,
    input  logic [NUM_CH*28-1:0] ch_addr_i,
    input  logic [NUM_CH*8-1:0]  ch_wbuffer_id_i,
    output logic [NUM_CH-1:0]    bank_valid_o,
    input  logic [NUM_CH-1:0]    bank_allowIn_i,
    output logic [NUM_CH*2-1:0]  bank_ch_id_o,
    output logic [NUM_CH*2-1:0]  bank_opcode_o,
    output logic [NUM_CH*28-1:0] bank_addr_o,
    output logic [NUM_CH*8-1:0]  bank_wbuffer_id_o
);

    localparam int unsigned IDW = 2;
    localparam int unsigned OPW = 2;
    localparam int unsigned AW  = 28;
    localparam int unsigned WBW = 8;
    // addr port carries addr[31:4], so the select field sits 4 bits lower
    localparam int unsigned SEL = BANK_SEL_LSB - 4;

    typedef struct packed {
        logic [IDW-1:0] ch_id;
        logic [OPW-1:0] opcode;
        logic [AW-1:0]  addr;
        logic [WBW-1:0] wbuffer_id;
    } req_t;

    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [IDW-1:0]    ptr_q [NUM_CH];
    logic [IDW-1:0]    ptr_d [NUM_CH];
    req_t              pl_q  [NUM_CH];
    req_t              pl_d  [NUM_CH];

    req_t              ch_req  [NUM_CH];
    logic [IDW-1:0]    ch_bank [NUM_CH];
    logic [NUM_CH-1:0] bank_gnt;
    logic [IDW-1:0]    gnt_id  [NUM_CH];

    // Unpack per-channel request fields and target bank
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_req[c].ch_id      = IDW'(c);
            ch_req[c].opcode     = ch_opcode_i[c*OPW +: OPW];
            ch_req[c].addr       = ch_addr_i[c*AW +: AW];
            ch_req[c].wbuffer_id = ch_wbuffer_id_i[c*WBW +: WBW];
            ch_bank[c]           = ch_addr_i[c*AW+SEL +: IDW];
        end
    end

    // State register: per-bank output stage and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            for (int unsigned b = 0; b < NUM_CH; b++) begin
                ptr_q[b] <= '0;
                pl_q[b]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned b = 0; b < NUM_CH; b++) begin
                ptr_q[b] <= ptr_d[b];
                pl_q[b]  <= pl_d[b];
            end
        end
    end

    // Arbitration and channel accept; allowIn is gated off while reset is held
    always_comb begin
        logic [IDW-1:0] idx;
        logic           load_en;
        bank_gnt     = '0;
        ch_allowIn_o = '0;
        idx          = '0;
        load_en      = 1'b0;
        for (int unsigned b = 0; b < NUM_CH; b++) begin
            gnt_id[b] = '0;
            load_en   = rst_i && (!valid_q[b] || bank_allowIn_i[b]);
            for (int unsigned off = 0; off < NUM_CH; off++) begin
                idx = IDW'(ptr_q[b] + IDW'(off));
                if (load_en && !bank_gnt[b] && ch_valid_i[idx] && (ch_bank[idx] == IDW'(b))) begin
                    bank_gnt[b] = 1'b1;
                    gnt_id[b]   = idx;
                end
            end
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned b = 0; b < NUM_CH; b++) begin
                if (bank_gnt[b] && (gnt_id[b] == IDW'(c))) begin
                    ch_allowIn_o[c] = 1'b1;
                end
            end
        end
    end

    // Next state: load on grant, empty on drain without load, hold otherwise
    always_comb begin
        valid_d = valid_q;
        for (int unsigned b = 0; b < NUM_CH; b++) begin
            ptr_d[b] = ptr_q[b];
            pl_d[b]  = pl_q[b];
            if (bank_gnt[b]) begin
                valid_d[b] = 1'b1;
                ptr_d[b]   = IDW'(gnt_id[b] + IDW'(1));
                pl_d[b]    = ch_req[gnt_id[b]];
            end else if (bank_allowIn_i[b]) begin
                valid_d[b] = 1'b0;
            end
        end
    end

    // Bank-side outputs straight from the output-stage registers
    always_comb begin
        bank_valid_o = valid_q;
        for (int unsigned b = 0; b < NUM_CH; b++) begin
            bank_ch_id_o[b*IDW +: IDW]      = pl_q[b].ch_id;
            bank_opcode_o[b*OPW +: OPW]     = pl_q[b].opcode;
            bank_addr_o[b*AW +: AW]         = pl_q[b].addr;
            bank_wbuffer_id_o[b*WBW +: WBW] = pl_q[b].wbuffer_id;
        end
    end

endmodule

// File: tb/tb_xbar_req_router.sv
// Scoreboard bench for xbar_req_router: a reference arbiter predicts grants,
// queues expected payloads per bank and checks them while held and on drain.
module tb_xbar_req_router;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   ch_valid;
    logic [3:0]   ch_allow;
    logic [7:0]   ch_opcode;
    logic [111:0] ch_addr;
    logic [31:0]  ch_wb;
    logic [3:0]   bank_valid;
    logic [3:0]   bank_allow;
    logic [7:0]   bank_ch_id;
    logic [7:0]   bank_opcode;
    logic [111:0] bank_addr;
    logic [31:0]  bank_wb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  mval;
    logic [1:0]  mptr [4];
    logic [39:0] sbq  [4][$];
    logic [3:0]  obs_allow;

    localparam logic [3:0] RR_ALLOW [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    localparam logic [1:0] RR_ID    [4] = '{2'd0, 2'd1, 2'd3, 2'd0};

    xbar_req_router dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ch_valid_i       (ch_valid),
        .ch_allowIn_o     (ch_allow),
        .ch_opcode_i      (ch_opcode),
        .ch_addr_i        (ch_addr),
        .ch_wbuffer_id_i  (ch_wb),
        .bank_valid_o     (bank_valid),
        .bank_allowIn_i   (bank_allow),
        .bank_ch_id_o     (bank_ch_id),
        .bank_opcode_o    (bank_opcode),
        .bank_addr_o      (bank_addr),
        .bank_wbuffer_id_o(bank_wb)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] tgt(input int c);
        return ch_addr[28*c +: 2];
    endfunction

    function automatic logic [39:0] ch_pl(input int c);
        return {2'(c), ch_opcode[2*c +: 2], ch_addr[28*c +: 28], ch_wb[8*c +: 8]};
    endfunction

    function automatic logic [39:0] bank_pl(input int b);
        return {bank_ch_id[2*b +: 2], bank_opcode[2*b +: 2], bank_addr[28*b +: 28], bank_wb[8*b +: 8]};
    endfunction

    task automatic set_req(input int c, input logic [1:0] bank, input logic [1:0] op, input logic [7:0] wb);
        ch_valid[c]          = 1'b1;
        ch_opcode[2*c +: 2]  = op;
        ch_addr[28*c +: 28]  = {26'($urandom), bank};
        ch_wb[8*c +: 8]      = wb;
    endtask

    task automatic model_reset();
        mval = '0;
        for (int b = 0; b < 4; b++) begin
            mptr[b] = '0;
            sbq[b].delete();
        end
    endtask

    // Called at a negedge with inputs driven; checks, advances the model, returns at the next negedge
    task automatic step();
        logic [3:0] ea;
        logic [3:0] g;
        logic [1:0] gid [4];
        #1;
        ea = '0;
        g  = '0;
        for (int b = 0; b < 4; b++) begin
            gid[b] = '0;
            if (!mval[b] || bank_allow[b]) begin
                for (int off = 0; off < 4; off++) begin
                    int c;
                    c = (int'(mptr[b]) + off) % 4;
                    if (!g[b] && ch_valid[c] && tgt(c) == 2'(b)) begin
                        g[b]   = 1'b1;
                        gid[b] = 2'(c);
                        ea[c]  = 1'b1;
                    end
                end
            end
        end
        obs_allow = ch_allow;
        check("ch_allowIn", 64'(ch_allow), 64'(ea));
        for (int b = 0; b < 4; b++) begin
            check($sformatf("bank_valid_b%0d", b), 64'(bank_valid[b]), 64'(mval[b]));
            if (mval[b] && sbq[b].size() > 0) begin
                check($sformatf("payload_b%0d", b), 64'(bank_pl(b)), 64'(sbq[b][0]));
                if (bank_allow[b]) void'(sbq[b].pop_front());
            end
            if (g[b]) begin
                sbq[b].push_back(ch_pl(int'(gid[b])));
                mval[b] = 1'b1;
                mptr[b] = 2'(gid[b] + 2'd1);
            end else if (bank_allow[b]) begin
                mval[b] = 1'b0;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b0;
        ch_valid   = '0;
        ch_opcode  = '0;
        ch_addr    = '0;
        ch_wb      = '0;
        bank_allow = '0;
        obs_allow  = '0;
        model_reset();
        @(negedge clk_i);
        ch_valid = 4'hF;
        @(negedge clk_i);
        #1;
        check("rst_bank_valid", 64'(bank_valid), 64'h0);
        check("rst_ch_allowIn", 64'(ch_allow), 64'h0);
        @(negedge clk_i);
        rst_i    = 1'b1;
        ch_valid = '0;

        // Round-robin on bank1 from reset pointer
        bank_allow = 4'hF;
        set_req(0, 2'd1, 2'd0, 8'h10);
        set_req(1, 2'd1, 2'd1, 8'h11);
        set_req(3, 2'd1, 2'd3, 8'h13);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr_allow_%0d", i), 64'(obs_allow), 64'(RR_ALLOW[i]));
            check($sformatf("rr_ch_id_%0d", i), 64'(bank_ch_id[3:2]), 64'(RR_ID[i]));
        end
        ch_valid = '0;
        step();

        // Single request ch2 -> bank3
        bank_allow = 4'b1000;
        set_req(2, 2'd3, 2'd1, 8'h5A);
        step();
        check("single_allow", 64'(obs_allow), 64'b0100);
        ch_valid = '0;
        check("single_valid", 64'(bank_valid), 64'b1000);
        check("single_ch_id", 64'(bank_ch_id[7:6]), 64'd2);
        check("single_opcode", 64'(bank_opcode[7:6]), 64'd1);
        check("single_wbuf", 64'(bank_wb[31:24]), 64'h5A);
        bank_allow = 4'hF;
        step();

        // Parallel, no conflicts
        for (int c = 0; c < 4; c++) set_req(c, 2'(c), 2'(3 - c), 8'(8'hA0 + c));
        step();
        check("par_allow", 64'(obs_allow), 64'hF);
        ch_valid = '0;
        check("par_valid", 64'(bank_valid), 64'hF);
        step();

        // Backpressure on bank0
        set_req(0, 2'd0, 2'd2, 8'h21);
        step();
        ch_valid   = '0;
        bank_allow = 4'hE;
        set_req(1, 2'd0, 2'd3, 8'h22);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_stall_allow_%0d", i), 64'(obs_allow[1]), 64'd0);
        end
        bank_allow = 4'hF;
        step();
        check("bp_grant", 64'(obs_allow[1]), 64'd1);
        ch_valid = '0;
        check("bp_next_valid", 64'(bank_valid[0]), 64'd1);
        check("bp_next_ch_id", 64'(bank_ch_id[1:0]), 64'd1);
        step();

        // Isolation: bank2 stalled, bank0 unaffected
        set_req(2, 2'd2, 2'd0, 8'h32);
        step();
        ch_valid   = '0;
        bank_allow = 4'b1011;
        set_req(0, 2'd2, 2'd1, 8'h40);
        set_req(1, 2'd0, 2'd2, 8'h41);
        step();
        check("iso_allow", 64'(obs_allow), 64'b0010);
        ch_valid[1] = 1'b0;
        check("iso_fwd_valid", 64'(bank_valid[0]), 64'd1);
        step();
        check("iso_pending", 64'(obs_allow), 64'b0000);

        // Fill every bank, then reset asynchronously
        ch_valid   = '0;
        bank_allow = '0;
        for (int c = 0; c < 4; c++) set_req(c, 2'(c), 2'(c), 8'(8'hC0 + c));
        step();
        ch_valid = '0;
        check("pre_rst_valid", 64'(bank_valid), 64'hF);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_valid", 64'(bank_valid), 64'h0);
        for (int c = 0; c < 4; c++) set_req(c, 2'(c), 2'd0, 8'h00);
        #1;
        check("rst_hold_allow", 64'(ch_allow), 64'h0);
        model_reset();
        @(negedge clk_i);
        rst_i      = 1'b1;
        ch_valid   = '0;
        bank_allow = 4'hF;
        set_req(0, 2'd0, 2'd1, 8'hE0);
        set_req(3, 2'd0, 2'd2, 8'hE3);
        step();
        check("post_rst_ptr", 64'(obs_allow), 64'b0001);
        ch_valid[0] = 1'b0;
        step();
        check("post_rst_ch3", 64'(obs_allow), 64'b1000);
        ch_valid = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
